// File: rtl/umi_pkg.sv
// umi_pkg
// Shared definitions for UMI leaf endpoints: command codes, packet field
// offsets, the endpoint FSM state encoding and size/lane helper functions.
package umi_pkg;

  // Request and response command codes (7-bit command field)
  localparam logic [6:0] CMD_WR     = 7'h01;
  localparam logic [6:0] CMD_RD     = 7'h02;
  localparam logic [6:0] CMD_WRACK  = 7'h03;
  localparam logic [6:0] CMD_RDRESP = 7'h04;
  localparam logic [6:0] CMD_ACK    = 7'h05;

  // Packet field bit offsets (LSB of each field)
  localparam int UMI_WRITE_BIT   = 0;
  localparam int UMI_CMD_LSB     = 1;    // [7:1]
  localparam int UMI_SIZE_LSB    = 8;    // [11:8]
  localparam int UMI_OPT_LSB     = 12;   // [31:12]
  localparam int UMI_DST_LO_LSB  = 32;   // dstaddr[31:0]
  localparam int UMI_SRC_LO_LSB  = 64;   // srcaddr[31:0]
  localparam int UMI_DATA_LO_LSB = 96;   // data[31:0]
  localparam int UMI_DATA_HI_LSB = 128;  // data[63:32]
  localparam int UMI_RSVD_LSB    = 160;  // [191:160], always zero in responses
  localparam int UMI_SRC_HI_LSB  = 192;  // srcaddr[63:32]
  localparam int UMI_DST_HI_LSB  = 224;  // dstaddr[63:32]

  // Endpoint FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } umi_state_e;

  // Unshifted byte mask for a transfer of 1<<size bytes
  function automatic logic [7:0] umi_size_wmask(input logic [3:0] size);
    case (size)
      4'd0:    return 8'h01;
      4'd1:    return 8'h03;
      4'd2:    return 8'h0F;
      4'd3:    return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  // Bit mask keeping only the low 1<<size bytes of a 64-bit word
  function automatic logic [63:0] umi_size_dmask(input logic [3:0] size);
    case (size)
      4'd0:    return 64'h0000_0000_0000_00FF;
      4'd1:    return 64'h0000_0000_0000_FFFF;
      4'd2:    return 64'h0000_0000_FFFF_FFFF;
      4'd3:    return 64'hFFFF_FFFF_FFFF_FFFF;
      default: return 64'h0000_0000_0000_0000;
    endcase
  endfunction

  // True when size is supported and the byte offset is naturally aligned
  function automatic logic umi_aligned(input logic [3:0] size, input logic [2:0] off);
    case (size)
      4'd0:    return 1'b1;
      4'd1:    return (off[0] == 1'b0);
      4'd2:    return (off[1:0] == 2'b00);
      4'd3:    return (off == 3'b000);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/umi_pack.sv
// umi_pack
// Combinational UMI packet builder: places individual fields into a UW-bit
// packet. Reserved bits [191:160] are driven to zero.
// Ports:
//   write, cmd, size, options  - header fields
//   dstaddr, srcaddr, data     - 64-bit address/data fields
//   packet                     - assembled UW-bit packet
module umi_pack
  import umi_pkg::*;
#(
  parameter int UW = 256
) (
  input  logic          write,
  input  logic [6:0]    cmd,
  input  logic [3:0]    size,
  input  logic [19:0]   options,
  input  logic [63:0]   dstaddr,
  input  logic [63:0]   srcaddr,
  input  logic [63:0]   data,
  output logic [UW-1:0] packet
);

  // Field placement; untouched bits (reserved) stay zero
  always_comb begin
    packet = {UW{1'b0}};
    packet[UMI_WRITE_BIT]          = write;
    packet[UMI_CMD_LSB +: 7]       = cmd;
    packet[UMI_SIZE_LSB +: 4]      = size;
    packet[UMI_OPT_LSB +: 20]      = options;
    packet[UMI_DST_LO_LSB +: 32]   = dstaddr[31:0];
    packet[UMI_DST_HI_LSB +: 32]   = dstaddr[63:32];
    packet[UMI_SRC_LO_LSB +: 32]   = srcaddr[31:0];
    packet[UMI_SRC_HI_LSB +: 32]   = srcaddr[63:32];
    packet[UMI_DATA_LO_LSB +: 32]  = data[31:0];
    packet[UMI_DATA_HI_LSB +: 32]  = data[63:32];
  end

endmodule

// File: rtl/umi_mem_endpoint.sv
// umi_mem_endpoint
// Terminates UMI requests at a single-port 64-bit memory with 1-cycle read
// latency. Handles posted writes, reads and acknowledged writes one at a
// time; unsupported requests are consumed silently.
// Optional feature: define UMI_MEM_ENDPOINT_ERRCNT_EN to build a saturating
// 16-bit counter of unsupported requests on err_count (tied 0 otherwise).
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   umi_in_valid/packet/ready       - request channel
//   umi_out_valid/packet/ready      - response channel
//   mem_en/we/addr/wmask/wrdata     - memory request (zero when mem_en=0)
//   mem_rddata                      - read data, one cycle after a read
//   err_count                       - unsupported-request count
module umi_mem_endpoint
  import umi_pkg::*;
#(
  parameter int AW = 64,
  parameter int UW = 256,
  parameter int DW = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            umi_in_valid,
  input  logic [UW-1:0]   umi_in_packet,
  output logic            umi_in_ready,
  output logic            umi_out_valid,
  output logic [UW-1:0]   umi_out_packet,
  input  logic            umi_out_ready,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW/8-1:0] mem_wmask,
  output logic [DW-1:0]   mem_wrdata,
  input  logic [DW-1:0]   mem_rddata,
  output logic [15:0]     err_count
);

  umi_state_e state_r;
  umi_state_e state_next_s;
  logic       in_ready_r;

  logic [6:0]  req_cmd_s;
  logic        req_write_s;
  logic [3:0]  req_size_s;
  logic [63:0] req_dst_s;
  logic [63:0] req_src_s;
  logic [63:0] req_data_s;
  logic [2:0]  req_off_s;
  logic        cmd_ok_s;
  logic        supported_s;
  logic        accept_s;
  logic        start_s;
  logic        req_is_wr_s;

  logic [6:0]  cmd_r;
  logic [3:0]  size_r;
  logic [63:0] dst_r;
  logic [63:0] src_r;

  logic          mem_en_r;
  logic          mem_we_r;
  logic [63:0]   mem_addr_r;
  logic [7:0]    mem_wmask_r;
  logic [63:0]   mem_wrdata_r;

  logic          out_valid_r;
  logic [UW-1:0] out_packet_r;
  logic [UW-1:0] resp_pkt_s;
  logic [6:0]    resp_cmd_s;
  logic [63:0]   resp_data_s;

  logic unused_s;

  // Request field extraction
  assign req_write_s = umi_in_packet[UMI_WRITE_BIT];
  assign req_cmd_s   = umi_in_packet[UMI_CMD_LSB +: 7];
  assign req_size_s  = umi_in_packet[UMI_SIZE_LSB +: 4];
  assign req_dst_s   = {umi_in_packet[UMI_DST_HI_LSB +: 32], umi_in_packet[UMI_DST_LO_LSB +: 32]};
  assign req_src_s   = {umi_in_packet[UMI_SRC_HI_LSB +: 32], umi_in_packet[UMI_SRC_LO_LSB +: 32]};
  assign req_data_s  = {umi_in_packet[UMI_DATA_HI_LSB +: 32], umi_in_packet[UMI_DATA_LO_LSB +: 32]};
  assign req_off_s   = req_dst_s[2:0];

  // Options and reserved request bits carry nothing this endpoint uses
  assign unused_s = ^{umi_in_packet[UMI_OPT_LSB +: 20], umi_in_packet[UMI_RSVD_LSB +: 32]};

  // Classify the request on the input: write bit must agree with the command
  always_comb begin
    cmd_ok_s    = 1'b0;
    req_is_wr_s = 1'b0;
    if (req_write_s == 1'b1) begin
      cmd_ok_s    = (req_cmd_s == CMD_WR);
      req_is_wr_s = 1'b1;
    end else begin
      cmd_ok_s    = (req_cmd_s == CMD_RD) || (req_cmd_s == CMD_WRACK);
      req_is_wr_s = (req_cmd_s == CMD_WRACK);
    end
  end

  assign supported_s = cmd_ok_s && umi_aligned(req_size_s, req_off_s);
  // in_ready_r is high exactly when the FSM sits in IDLE
  assign accept_s    = in_ready_r && umi_in_valid;
  assign start_s     = accept_s && supported_s;

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_next_s = ST_EXEC;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (cmd_r == CMD_WR) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        state_next_s = ST_RESP;
      end
      ST_RESP: begin
        if (umi_out_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register; ready is registered from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      in_ready_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      in_ready_r <= (state_next_s == ST_IDLE);
    end
  end

  // Capture the request fields still needed after the accept cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_r  <= 7'd0;
      size_r <= 4'd0;
      dst_r  <= 64'd0;
      src_r  <= 64'd0;
    end else if (start_s) begin
      cmd_r  <= req_cmd_s;
      size_r <= req_size_s;
      dst_r  <= req_dst_s;
      src_r  <= req_src_s;
    end else begin
      cmd_r  <= cmd_r;
      size_r <= size_r;
      dst_r  <= dst_r;
      src_r  <= src_r;
    end
  end

  // Memory strobe: loaded on accept so it is high for the single EXEC cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en_r     <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= 64'd0;
      mem_wmask_r  <= 8'd0;
      mem_wrdata_r <= 64'd0;
    end else if (start_s) begin
      mem_en_r   <= 1'b1;
      mem_we_r   <= req_is_wr_s;
      mem_addr_r <= {req_dst_s[63:3], 3'b000};
      if (req_is_wr_s) begin
        mem_wmask_r  <= umi_size_wmask(req_size_s) << req_off_s;
        mem_wrdata_r <= req_data_s << {req_off_s, 3'b000};
      end else begin
        mem_wmask_r  <= 8'd0;
        mem_wrdata_r <= 64'd0;
      end
    end else begin
      mem_en_r     <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= 64'd0;
      mem_wmask_r  <= 8'd0;
      mem_wrdata_r <= 64'd0;
    end
  end

  // Response fields: read data is shifted down to lane 0 and trimmed to size
  always_comb begin
    resp_cmd_s  = CMD_ACK;
    resp_data_s = 64'd0;
    if (cmd_r == CMD_RD) begin
      resp_cmd_s  = CMD_RDRESP;
      resp_data_s = (mem_rddata >> {dst_r[2:0], 3'b000}) & umi_size_dmask(size_r);
    end else begin
      resp_cmd_s  = CMD_ACK;
      resp_data_s = 64'd0;
    end
  end

  umi_pack #(
    .UW (UW)
  ) u_pack (
    .write   (1'b1),
    .cmd     (resp_cmd_s),
    .size    (size_r),
    .options (20'd0),
    .dstaddr (src_r),
    .srcaddr (dst_r),
    .data    (resp_data_s),
    .packet  (resp_pkt_s)
  );

  // Response register: loaded in WAIT (read data valid), held until accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r  <= 1'b0;
      out_packet_r <= {UW{1'b0}};
    end else begin
      case (state_r)
        ST_WAIT: begin
          out_valid_r  <= 1'b1;
          out_packet_r <= resp_pkt_s;
        end
        ST_RESP: begin
          if (umi_out_ready) begin
            out_valid_r  <= 1'b0;
            out_packet_r <= {UW{1'b0}};
          end else begin
            out_valid_r  <= out_valid_r;
            out_packet_r <= out_packet_r;
          end
        end
        default: begin
          out_valid_r  <= 1'b0;
          out_packet_r <= {UW{1'b0}};
        end
      endcase
    end
  end

`ifdef UMI_MEM_ENDPOINT_ERRCNT_EN
  logic [15:0] err_count_r;

  // Saturating count of consumed-but-unsupported requests
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count_r <= 16'd0;
    end else if (accept_s && !supported_s && (err_count_r != 16'hFFFF)) begin
      err_count_r <= err_count_r + 16'd1;
    end else begin
      err_count_r <= err_count_r;
    end
  end

  assign err_count = err_count_r;
`else
  assign err_count = 16'd0;
`endif

  assign umi_in_ready   = in_ready_r;
  assign umi_out_valid  = out_valid_r;
  assign umi_out_packet = out_packet_r;
  assign mem_en         = mem_en_r;
  assign mem_we         = mem_we_r;
  assign mem_addr       = mem_addr_r;
  assign mem_wmask      = mem_wmask_r;
  assign mem_wrdata     = mem_wrdata_r;

endmodule

// File: tb/tb_umi_mem_endpoint.sv
// tb_umi_mem_endpoint
// Scoreboard bench: each directed request pushes its expected memory access
// and expected response into queues; a monitor pops and compares whenever the
// DUT strobes memory or presents a response.
module tb_umi_mem_endpoint;

  localparam logic [6:0] WR     = 7'h01;
  localparam logic [6:0] RD     = 7'h02;
  localparam logic [6:0] WRACK  = 7'h03;
  localparam logic [6:0] RDRESP = 7'h04;
  localparam logic [6:0] ACK    = 7'h05;
`ifdef UMI_MEM_ENDPOINT_ERRCNT_EN
  localparam logic [15:0] ERR_EXP = 16'd2;
`else
  localparam logic [15:0] ERR_EXP = 16'd0;
`endif

  logic         clk;
  logic         reset;
  logic         umi_in_valid;
  logic [255:0] umi_in_packet;
  logic         umi_in_ready;
  logic         umi_out_valid;
  logic [255:0] umi_out_packet;
  logic         umi_out_ready;
  logic         mem_en;
  logic         mem_we;
  logic [63:0]  mem_addr;
  logic [7:0]   mem_wmask;
  logic [63:0]  mem_wrdata;
  logic [63:0]  mem_rddata;
  logic [15:0]  err_count;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [7:0]  wmask;
    logic [63:0] wrdata;
  } mexp_t;

  mexp_t        mq[$];
  logic [255:0] rq[$];
  int           checks = 0;
  int           failures = 0;
  int           handshakes = 0;
  logic         mon_en = 1'b0;
  logic [63:0]  rd_value = 64'd0;

  umi_mem_endpoint dut (
    .clk            (clk),
    .reset          (reset),
    .umi_in_valid   (umi_in_valid),
    .umi_in_packet  (umi_in_packet),
    .umi_in_ready   (umi_in_ready),
    .umi_out_valid  (umi_out_valid),
    .umi_out_packet (umi_out_packet),
    .umi_out_ready  (umi_out_ready),
    .mem_en         (mem_en),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wmask      (mem_wmask),
    .mem_wrdata     (mem_wrdata),
    .mem_rddata     (mem_rddata),
    .err_count      (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] mkpkt(input logic w, input logic [6:0] cmd,
                                         input logic [3:0] sz, input logic [19:0] opt,
                                         input logic [63:0] dst, input logic [63:0] src,
                                         input logic [63:0] data);
    logic [255:0] p;
    p = 256'd0;
    p[0]       = w;
    p[7:1]     = cmd;
    p[11:8]    = sz;
    p[31:12]   = opt;
    p[63:32]   = dst[31:0];
    p[255:224] = dst[63:32];
    p[95:64]   = src[31:0];
    p[223:192] = src[63:32];
    p[127:96]  = data[31:0];
    p[159:128] = data[63:32];
    return p;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic exp_mem(input logic we, input logic [63:0] addr, input logic [7:0] wmask,
                         input logic [63:0] wrdata);
    mexp_t e;
    e.we = we; e.addr = addr; e.wmask = wmask; e.wrdata = wrdata;
    mq.push_back(e);
  endtask

  task automatic exp_resp(input logic [6:0] cmd, input logic [3:0] sz, input logic [63:0] dst,
                          input logic [63:0] src, input logic [63:0] data);
    rq.push_back(mkpkt(1'b1, cmd, sz, 20'd0, dst, src, data));
  endtask

  // Present one request and hold it until the DUT takes it
  task automatic send(input logic [255:0] p);
    int n;
    n = 0;
    @(negedge clk);
    umi_in_valid  = 1'b1;
    umi_in_packet = p;
    while (!umi_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL send_timeout ready=%0b required=1", umi_in_ready);
    end
    @(posedge clk);
    #1;
    umi_in_valid  = 1'b0;
    umi_in_packet = 256'd0;
  endtask

  // Wait for every expectation to be consumed, bounded
  task automatic drain(input string name);
    int n;
    n = 0;
    while ((mq.size() != 0 || rq.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL drain_%s pending_mem=%0d pending_resp=%0d required=0", name, mq.size(), rq.size());
    end
    repeat (3) @(negedge clk);
  endtask

  // Memory model: returns rd_value in the cycle after a read strobe
  initial begin
    logic rd_pend;
    mem_rddata = 64'hDEAD_BEEF_CAFE_F00D;
    forever begin
      @(negedge clk);
      rd_pend = mem_en && !mem_we;
      @(posedge clk);
      #1;
      mem_rddata = rd_pend ? rd_value : 64'hDEAD_BEEF_CAFE_F00D;
    end
  end

  // Monitor: scoreboard pops on memory strobes and response handshakes
  initial begin
    mexp_t        me;
    logic [255:0] ep;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (mem_en) begin
        if (mq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL mem_unexpected addr=%0h we=%0b required=no_access", mem_addr, mem_we);
        end else begin
          me = mq.pop_front();
          check("mem_we", {255'd0, mem_we}, {255'd0, me.we});
          check("mem_addr", {192'd0, mem_addr}, {192'd0, me.addr});
          check("mem_wmask", {248'd0, mem_wmask}, {248'd0, me.wmask});
          check("mem_wrdata", {192'd0, mem_wrdata}, {192'd0, me.wrdata});
        end
      end else begin
        check("mem_idle_zero", {119'd0, mem_we, mem_addr, mem_wmask, mem_wrdata}, 256'd0);
      end
      if (umi_out_valid) begin
        check("in_ready_during_resp", {255'd0, umi_in_ready}, 256'd0);
        if (rq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL resp_unexpected packet=%0h required=no_response", umi_out_packet);
        end else if (umi_out_ready) begin
          ep = rq.pop_front();
          check("resp_pkt", umi_out_packet, ep);
          handshakes++;
        end else begin
          check("resp_pkt_stall", umi_out_packet, rq[0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time_limit_reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hs0;
    reset         = 1'b1;
    umi_in_valid  = 1'b0;
    umi_in_packet = 256'd0;
    umi_out_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {255'd0, umi_in_ready}, 256'd0);
    check("rst_out_valid", {255'd0, umi_out_valid}, 256'd0);
    check("rst_out_packet", umi_out_packet, 256'd0);
    check("rst_mem_en", {255'd0, mem_en}, 256'd0);
    check("rst_mem_we", {255'd0, mem_we}, 256'd0);
    check("rst_err_count", {240'd0, err_count}, 256'd0);
    mon_en = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_reset", {255'd0, umi_in_ready}, {255'd0, 1'b1});

    // Posted writes: full word, then a single byte at offset 5
    exp_mem(1'b1, 64'h1000, 8'hFF, 64'h1122_3344_5566_7788);
    send(mkpkt(1'b1, WR, 4'd3, 20'hABCDE, 64'h1000, 64'h0, 64'h1122_3344_5566_7788));
    exp_mem(1'b1, 64'h1000, 8'h20, 64'h0000_AB00_0000_0000);
    send(mkpkt(1'b1, WR, 4'd0, 20'h00001, 64'h1005, 64'h0, 64'h0000_0000_0000_00AB));
    drain("posted_wr");

    // Halfword read from the top lane
    rd_value = 64'hBEEF_0000_0000_0000;
    exp_mem(1'b0, 64'h2000, 8'h00, 64'h0);
    exp_resp(RDRESP, 4'd1, 64'h9000, 64'h2006, 64'h0000_0000_0000_BEEF);
    send(mkpkt(1'b0, RD, 4'd1, 20'hFFFFF, 64'h2006, 64'h9000, 64'h0));
    drain("rd_half");

    // Word read at offset 4: upper half of memory word, trimmed to 32 bits
    rd_value = 64'h1122_3344_5566_7788;
    exp_mem(1'b0, 64'h5000, 8'h00, 64'h0);
    exp_resp(RDRESP, 4'd2, 64'h77, 64'h5004, 64'h0000_0000_1122_3344);
    send(mkpkt(1'b0, RD, 4'd2, 20'h0, 64'h5004, 64'h77, 64'h0));
    drain("rd_word");

    // Full read with 5 cycles of backpressure and high address bits
    rd_value = 64'h0123_4567_89AB_CDEF;
    exp_mem(1'b0, 64'h4000_0000_0000_0010, 8'h00, 64'h0);
    exp_resp(RDRESP, 4'd3, 64'hA5A5_0000_1234_5678, 64'h4000_0000_0000_0010, 64'h0123_4567_89AB_CDEF);
    hs0 = handshakes;
    umi_out_ready = 1'b0;
    send(mkpkt(1'b0, RD, 4'd3, 20'h12345, 64'h4000_0000_0000_0010, 64'hA5A5_0000_1234_5678, 64'h0));
    n = 0;
    while (!umi_out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_seen", {255'd0, umi_out_valid}, {255'd0, 1'b1});
    repeat (5) @(posedge clk);
    #1 umi_out_ready = 1'b1;
    drain("rd_backpressure");
    check("bp_handshakes", handshakes - hs0, 256'd1);

    // Unsupported: unknown command, then a misaligned halfword read
    send(mkpkt(1'b0, 7'h10, 4'd3, 20'h0, 64'h8000, 64'h1, 64'h0));
    send(mkpkt(1'b0, RD, 4'd1, 20'h0, 64'h3, 64'h1, 64'h0));
    repeat (6) @(negedge clk);
    check("unsup_ready", {255'd0, umi_in_ready}, {255'd0, 1'b1});
    check("err_count", {240'd0, err_count}, {240'd0, ERR_EXP});

    // Acknowledged word write at offset 4
    hs0 = handshakes;
    exp_mem(1'b1, 64'h6000, 8'hF0, 64'hCAFE_BABE_0000_0000);
    exp_resp(ACK, 4'd2, 64'h8888, 64'h6004, 64'h0);
    send(mkpkt(1'b0, WRACK, 4'd2, 20'h55555, 64'h6004, 64'h8888, 64'h0000_0000_CAFE_BABE));
    drain("wrack");
    check("wrack_handshakes", handshakes - hs0, 256'd1);

    // Reset while waiting for read data: response must be dropped
    rd_value = 64'h7777_7777_7777_7777;
    exp_mem(1'b0, 64'hA000, 8'h00, 64'h0);
    send(mkpkt(1'b0, RD, 4'd3, 20'h0, 64'hA000, 64'hB000, 64'h0));
    n = 0;
    while (!mem_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_exec_seen", {255'd0, mem_en}, {255'd0, 1'b1});
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_out_valid", {255'd0, umi_out_valid}, 256'd0);
    check("rst_mid_in_ready", {255'd0, umi_in_ready}, 256'd0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_ready_back", {255'd0, umi_in_ready}, {255'd0, 1'b1});
    check("rst_mid_err_count", {240'd0, err_count}, 256'd0);
    repeat (4) @(negedge clk);

    hs0 = handshakes;
    exp_mem(1'b1, 64'h7000, 8'hFF, 64'h5555_AAAA_5555_AAAA);
    exp_resp(ACK, 4'd3, 64'h1234, 64'h7000, 64'h0);
    send(mkpkt(1'b0, WRACK, 4'd3, 20'h0, 64'h7000, 64'h1234, 64'h5555_AAAA_5555_AAAA));
    drain("wrack_after_reset");
    check("post_reset_handshakes", handshakes - hs0, 256'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
